serial_adder: RTL and testbench



---
 rtl/full_adder.sv | 33 +++
 rtl/half_adder.sv | 15 +
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/full_adder.sv
// Full adder made from two half adders; the two partial carries can never both be
// set, so an OR combines them.
//   a_i, b_i - operand bits
//   cin_i    - carry in
//   sum_o    - sum bit
//   cout_o   - carry out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic s0, c0, c1;

  half_adder u_ha0 (
    .a_i     (a_i),
    .b_i     (b_i),
    .sum_o   (s0),
    .carry_o (c0)
  );

  half_adder u_ha1 (
    .a_i     (s0),
    .b_i     (cin_i),
    .sum_o   (sum_o),
    .carry_o (c1)
  );

  assign cout_o = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Half adder cell: single-bit add without carry-in.
//   a_i, b_i  - operand bits
//   sum_o     - a_i ^ b_i
//   carry_o   - a_i & b_i
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands and a carry-in on start, adds one
// bit per clock LSB first through a registered carry, then publishes sum/carry with a
// one-cycle done pulse.
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   start_i  - begin an addition (only honoured while idle)
//   a_i, b_i - operands, captured on accepted start
//   cin_i    - carry-in, captured on accepted start
//   busy_o   - addition in progress (exactly WIDTH cycles)
//   done_o   - one-cycle pulse when sum_o/carry_o have just updated
//   sum_o    - registered result, held until next completion
//   carry_o  - registered carry-out, held until next completion
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             c_q, c_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic fa_sum, fa_cout;
  logic last_bit;

  full_adder u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (c_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  assign last_bit = (state_q == StRun) && (cnt_q == CntLast);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = StRun;
      StRun:  if (last_bit) state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    if (state_q == StIdle) begin
      if (start_i) begin
        a_sh_d = a_i;
        b_sh_d = b_i;
        c_d    = cin_i;
        s_sh_d = '0;
        cnt_d  = '0;
      end
    end else begin
      // Sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
      s_sh_d = (s_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      c_d    = fa_cout;
      cnt_d  = cnt_q + CntW'(1);
      if (last_bit) begin
        sum_d   = s_sh_d;
        carry_d = fa_cout;
        done_d  = 1'b1;
      end
    end
  end

  // Outputs.
  always_comb begin
    busy_o  = (state_q == StRun);
    done_o  = done_q;
    sum_o   = sum_q;
    carry_o = carry_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, carry1;
  logic [0:0] sum1;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start8),
    .a_i     (a8),
    .b_i     (b8),
    .cin_i   (cin8),
    .busy_o  (busy8),
    .done_o  (done8),
    .sum_o   (sum8),
    .carry_o (carry8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start1),
    .a_i     (a1),
    .b_i     (b1),
    .cin_i   (cin1),
    .busy_o  (busy1),
    .done_o  (done1),
    .sum_o   (sum1),
    .carry_o (carry1)
  );

  // Drives a start pulse on the 8-bit DUT; returns at the negedge after the start edge.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(negedge clk);
    start8 = 1'b0; a8 = $urandom; b8 = $urandom; cin8 = $urandom;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({busy8, done8, carry8, sum8} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b done=%b carry=%b sum=%h want all 0",
               busy8, done8, carry8, sum8);
    end
    n_vec++;
    if ({busy1, done1, carry1, sum1} !== 4'h0) begin
      n_fail++;
      $display("FAIL reset1: got busy=%b done=%b carry=%b sum=%h want all 0",
               busy1, done1, carry1, sum1);
    end
  endtask

  // Full check of timing profile and result for one addition.
  task automatic test_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] exp_sum, input logic exp_carry, input string nm);
    int bad;
    launch8(a, b, c);
    bad = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_busy: got %0d bad busy/done cycles want 0", nm, bad);
    end
    @(negedge clk);
    n_vec++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: got done=%b busy=%b want done=1 busy=0", nm, done8, busy8);
    end
    n_vec++;
    if ({carry8, sum8} !== {exp_carry, exp_sum}) begin
      n_fail++;
      $display("FAIL %s_result: got %b/%h want %b/%h", nm, carry8, sum8, exp_carry, exp_sum);
    end
    @(negedge clk);
    n_vec++;
    if (done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: got done=%b want 0 one cycle later", nm, done8);
    end
  endtask

  task automatic test_start_ignored();
    int extra;
    launch8(8'h10, 8'h20, 1'b0);
    // now at cycle 1; re-pulse start across the edge ending cycle 3
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if (done8 !== 1'b1 || {carry8, sum8} !== 9'h030) begin
      n_fail++;
      $display("FAIL start_ignored: got done=%b %b/%h want done=1 0/30", done8, carry8, sum8);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL start_ignored_drop: got %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    launch8(8'h12, 8'h34, 1'b0);
    repeat (8) @(negedge clk);
    n_vec++;
    if (done8 !== 1'b1 || sum8 !== 8'h46) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b sum=%h want done=1 sum=46", done8, sum8);
    end
    // Start in the done cycle.
    start8 = 1'b1; a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    bad = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'h46) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b_hold: got %0d bad cycles want 0", bad);
    end
    @(negedge clk);
    n_vec++;
    if (done8 !== 1'b1 || {carry8, sum8} !== 9'h007) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b %b/%h want done=1 0/07", done8, carry8, sum8);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    launch8(8'h55, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy8, done8, carry8, sum8} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b carry=%b sum=%h want all 0",
               busy8, done8, carry8, sum8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_nodone: got %0d busy/done cycles want 0", bad);
    end
    test_add(8'h55, 8'h0F, 1'b0, 8'h64, 1'b0, "after_reset");
  endtask

  task automatic test_random8();
    logic [7:0] a, b;
    logic       c;
    logic [8:0] exp;
    int         bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {8'h0, c};
      launch8(a, b, c);
      repeat (8) @(negedge clk);
      n_vec++;
      if (done8 !== 1'b1 || {carry8, sum8} !== exp) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL rand8 %h+%h+%b: got done=%b %h want %h", a, b, c, done8,
                   {carry8, sum8}, exp);
      end
    end
  endtask

  task automatic test_random1();
    logic [0:0] a, b;
    logic       c;
    logic [1:0] exp;
    int         bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {1'b0, c};
      @(negedge clk);
      start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
      @(negedge clk);
      start1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~c;
      if (busy1 !== 1'b1) begin
        n_fail++;
        bad++;
        if (bad <= 5) $display("FAIL rand1_busy: got %b want 1", busy1);
      end
      @(negedge clk);
      n_vec++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || {carry1, sum1} !== exp) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL rand1 %b+%b+%b: got done=%b busy=%b %b want %b", a, b, c, done1,
                   busy1, {carry1, sum1}, exp);
      end
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
    test_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ripple");
    test_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a");
    test_add(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0, "7f_80");
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    test_random1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
